uart_tx_word: RTL and testbench

UART transmitter that returns 16-bit CPU results to the host over the serial line. It is the send side of the loader link. A word is accepted through a valid/ready handshake and sent as two 8N1 frames, low byte first, the same byte order the loader uses on receive. It sits in top_cpu beside the receive path and is fed by the result register (register C) or a debug source.

---
 rtl/cpu_uart_pkg.sv | 12 +
 rtl/uart_tx_byte.sv | 63 ++++++
 rtl/uart_tx_word.sv | 52 +++++
 tb/tb_uart_tx_word.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/cpu_uart_pkg.sv
// cpu_uart_pkg: shared UART timing default, tx state encoding and line levels
package cpu_uart_pkg;
  localparam int CLKS_PER_BIT_DEF = 234;
  typedef logic [1:0] tx_state_t;
  localparam tx_state_t IDLE  = 2'd0;
  localparam tx_state_t START = 2'd1;
  localparam tx_state_t DATA  = 2'd2;
  localparam tx_state_t STOP  = 2'd3;
  localparam logic UART_IDLE  = 1'b1;
  localparam logic UART_START = 1'b0;
  localparam logic UART_STOP  = 1'b1;
endpackage

// File: rtl/uart_tx_byte.sv
// uart_tx_byte: 8N1 byte framer with baud counter and registered line output
module uart_tx_byte
  import cpu_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       byte_valid,
  input  logic [7:0] byte_data,
  output logic       byte_ready,
  output logic       byte_done,
  output logic       tx
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  tx_state_t  state;
  logic [CW-1:0] cnt;
  logic [2:0] idx;
  logic [2:0] nidx;
  logic       last;
  assign last       = cnt == CW'(CLKS_PER_BIT - 1);
  assign nidx       = idx + 3'd1;
  assign byte_done  = state == STOP && last;
  assign byte_ready = state == IDLE || byte_done;
  // byte_data is read live; the word side keeps it stable for the whole frame
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      tx    <= UART_IDLE;
    end else begin
      cnt <= (state == IDLE || last) ? '0 : cnt + 1'b1;
      case (state)
        IDLE:
          if (byte_valid) begin
            state <= START;
            tx    <= UART_START;
          end
        START:
          if (last) begin
            state <= DATA;
            idx   <= '0;
            tx    <= byte_data[0];
          end
        DATA:
          if (last) begin
            if (idx == 3'd7) begin
              state <= STOP;
              tx    <= UART_STOP;
            end else begin
              idx <= nidx;
              tx  <= byte_data[nidx];
            end
          end
        STOP:
          if (last) begin
            state <= byte_valid ? START : IDLE;
            tx    <= byte_valid ? UART_START : UART_IDLE;
          end
      endcase
    end
endmodule

// File: rtl/uart_tx_word.sv
// uart_tx_word: sends a DATA_W word as consecutive 8N1 frames, low byte first
module uart_tx_word
  import cpu_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int DATA_W       = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              uart_tx,
  output logic              busy
);
  localparam int NB = DATA_W / 8;
  localparam int BW = NB > 1 ? $clog2(NB) : 1;
  logic [DATA_W-1:0] sh;
  logic [BW-1:0]     bcnt;
  logic act, more, accept, byte_valid, byte_ready, byte_done;
  assign more       = bcnt != BW'(NB - 1);
  assign in_ready   = ~act & byte_ready;
  assign busy       = ~in_ready;
  assign accept     = in_valid & in_ready;
  // requesting during the last stop cycle chains the next start bit directly
  assign byte_valid = accept | (act & more);
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      sh   <= '0;
      bcnt <= '0;
      act  <= 1'b0;
    end else if (accept) begin
      sh   <= in_data;
      bcnt <= '0;
      act  <= 1'b1;
    end else if (byte_done) begin
      if (more) begin
        sh   <= sh >> 8;
        bcnt <= bcnt + 1'b1;
      end else
        act <= 1'b0;
    end
  uart_tx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_byte (
    .clk       (clk),
    .reset_n   (reset_n),
    .byte_valid(byte_valid),
    .byte_data (sh[7:0]),
    .byte_ready(byte_ready),
    .byte_done (byte_done),
    .tx        (uart_tx)
  );
endmodule

// File: tb/tb_uart_tx_word.sv
// tb_uart_tx_word: directed checks of framing, timing, busy-ignore and reset
module tb_uart_tx_word;
  localparam int C = 234;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic in_valid = 1'b0;
  logic [15:0] in_data = '0;
  logic in_ready, uart_tx, busy;
  int cyc = 0;
  int errors = 0;
  int checks = 0;
  int t0, fall_cyc, f0, f1, f2, f3;
  logic [7:0] b0, b1, b2, b3;
  logic seen_low;

  uart_tx_word #(.CLKS_PER_BIT(C), .DATA_W(16)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .in_valid(in_valid),
    .in_data (in_data),
    .in_ready(in_ready),
    .uart_tx (uart_tx),
    .busy    (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [15:0] w);
    @(negedge clk);
    check("pre_accept_tx", uart_tx, 1);
    in_valid = 1'b1;
    in_data  = w;
    @(posedge clk);
    #1;
    t0 = cyc;
    in_valid = 1'b0;
    check("start_at_t1", uart_tx, 0);
  endtask

  task automatic rx_byte(output logic [7:0] b);
    int n = 0;
    b = '0;
    @(negedge clk);
    while (uart_tx !== 1'b0 && n < 30 * C) begin
      @(negedge clk);
      n++;
    end
    if (uart_tx !== 1'b0) begin
      check("rx_timeout", 0, 1);
      return;
    end
    fall_cyc = cyc;
    repeat (C / 2) @(negedge clk);
    check("start_mid", uart_tx, 0);
    for (int i = 0; i < 8; i++) begin
      repeat (C) @(negedge clk);
      b[i] = uart_tx;
    end
    repeat (C) @(negedge clk);
    check("stop_mid", uart_tx, 1);
  endtask

  initial begin
    repeat (5) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    check("rst_tx", uart_tx, 1);
    check("rst_ready", in_ready, 1);
    check("rst_busy", busy, 0);
    seen_low = 1'b0;
    repeat (2000) begin
      @(negedge clk);
      if (uart_tx !== 1'b1) seen_low = 1'b1;
    end
    check("idle_quiet", seen_low, 0);

    send(16'h130B);
    check("accept_busy", busy, 1);
    rx_byte(b0);
    rx_byte(b1);
    check("single_lo", b0, 8'h0B);
    check("single_hi", b1, 8'h13);
    check("loopback_word", {b1, b0}, 16'h130B);
    wait_until(t0 + 20 * C - 1);
    check("ready_before_end", in_ready, 0);
    wait_until(t0 + 20 * C);
    check("ready_t4681", in_ready, 1);

    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 16'h0E00;
    @(posedge clk);
    #1;
    in_data = 16'hFFFF;
    rx_byte(b0); f0 = fall_cyc;
    rx_byte(b1); f1 = fall_cyc;
    rx_byte(b2); f2 = fall_cyc;
    in_valid = 1'b0;
    rx_byte(b3); f3 = fall_cyc;
    check("b2b_0", b0, 8'h00);
    check("b2b_1", b1, 8'h0E);
    check("b2b_2", b2, 8'hFF);
    check("b2b_3", b3, 8'hFF);
    check("inter_byte_gap", f1 - f0, 10 * C);
    check("inter_word_gap", f2 - f0, 20 * C + 1);
    check("inter_byte_gap2", f3 - f2, 10 * C);
    wait_until(f2 + 20 * C);
    check("b2b_done_ready", in_ready, 1);

    send(16'h3C96);
    fork
      begin
        rx_byte(b0);
        rx_byte(b1);
      end
      begin
        wait_until(t0 + 500);
        in_valid = 1'b1;
        in_data  = 16'hAAAA;
        check("busy_ready_low", in_ready, 0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
      end
    join
    check("busy_lo", b0, 8'h96);
    check("busy_hi", b1, 8'h3C);
    wait_until(t0 + 20 * C);
    check("busy_end_ready", in_ready, 1);
    seen_low = 1'b0;
    repeat (2 * C) begin
      @(negedge clk);
      if (uart_tx !== 1'b1 || in_ready !== 1'b1) seen_low = 1'b1;
    end
    check("no_late_accept", seen_low, 0);

    send(16'h0000);
    wait_until(t0 + 3000);
    check("pre_reset_tx", uart_tx, 0);
    #3;
    reset_n = 1'b0;
    #1;
    check("async_rst_tx", uart_tx, 1);
    check("async_rst_ready", in_ready, 1);
    check("async_rst_busy", busy, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    send(16'h5A5A);
    rx_byte(b0);
    rx_byte(b1);
    check("post_rst_word", {b1, b0}, 16'h5A5A);
    wait_until(t0 + 20 * C);
    check("post_rst_ready", in_ready, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
